// File: rtl/bp_be_operand_fetch.sv
// Operand fetch stage: accepts issue packets, reads the int/fp register file,
// forwards in-flight writebacks and presents one dispatch beat per instruction.
module bp_be_operand_fetch #(
  parameter int vaddr_width_p    = 39,
  parameter int instr_width_p    = 32,
  parameter int dpath_width_p    = 66,
  parameter int reg_addr_width_p = 5
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          flush_i,

  input  logic                          issue_v_i,
  output logic                          issue_ready_o,
  input  logic [vaddr_width_p-1:0]      issue_pc_i,
  input  logic [instr_width_p-1:0]      issue_instr_i,
  input  logic [3*reg_addr_width_p-1:0] issue_src_addr_i,
  input  logic [2:0]                    issue_src_fp_i,
  input  logic                          issue_imm_v_i,
  input  logic [dpath_width_p-1:0]      issue_imm_i,

  output logic [2:0]                    rf_r_v_o,
  output logic [2:0]                    rf_r_fp_o,
  output logic [3*reg_addr_width_p-1:0] rf_r_addr_o,
  input  logic [3*dpath_width_p-1:0]    rf_r_data_i,

  input  logic                          wb_v_i,
  input  logic                          wb_fp_i,
  input  logic [reg_addr_width_p-1:0]   wb_addr_i,
  input  logic [dpath_width_p-1:0]      wb_data_i,

  output logic                          dispatch_v_o,
  input  logic                          dispatch_ready_i,
  output logic [vaddr_width_p-1:0]      dispatch_pc_o,
  output logic [instr_width_p-1:0]      dispatch_instr_o,
  output logic [3*dpath_width_p-1:0]    dispatch_rs_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e                          state_r, state_n;

  logic [vaddr_width_p-1:0]        pc_r;
  logic [instr_width_p-1:0]        instr_r;
  logic [dpath_width_p-1:0]        imm_r;
  logic                            imm_v_r;
  logic [3*reg_addr_width_p-1:0]   src_addr_r;
  logic [2:0]                      src_fp_r;
  logic [2:0]                      src_used_r;

  logic                            wb_v_r;
  logic                            wb_fp_r;
  logic [reg_addr_width_p-1:0]     wb_addr_r;
  logic [dpath_width_p-1:0]        wb_data_r;

  logic [dpath_width_p-1:0]        hold_rs_r [3];
  logic [dpath_width_p-1:0]        read_rs   [3];
  logic [dpath_width_p-1:0]        hold_upd  [3];

  logic                            accept;

  // A writeback feeds a source only if it targets the same file and index;
  // int x0 is hardwired to zero and must never pick up a bypassed value.
  function automatic logic wb_match(
    input logic                        v,
    input logic                        fp,
    input logic [reg_addr_width_p-1:0] addr,
    input logic                        src_fp,
    input logic [reg_addr_width_p-1:0] src_addr,
    input logic                        used
  );
    return v && (fp == src_fp) && (addr == src_addr) && used
           && !(!src_fp && (src_addr == '0));
  endfunction

  assign dispatch_v_o  = reset_n_i && !flush_i && (state_r != IDLE);
  assign issue_ready_o = reset_n_i && !flush_i
                         && ((state_r == IDLE) || (dispatch_v_o && dispatch_ready_i));
  assign accept        = issue_v_i && issue_ready_o;

  // Slot 2 carries the immediate instead of rs3 when imm_v is set.
  assign rf_r_v_o    = {3{accept}} & {~issue_imm_v_i, 2'b11};
  assign rf_r_fp_o   = issue_src_fp_i;
  assign rf_r_addr_o = issue_src_addr_i;
  assign src_used_r  = {~imm_v_r, 2'b11};

  assign dispatch_pc_o    = pc_r;
  assign dispatch_instr_o = instr_r;

  // NOTE: every always_comb output is given a default before any branch so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    dispatch_rs_o = '0;
    for (int i = 0; i < 3; i++) begin
      read_rs[i] = rf_r_data_i[i*dpath_width_p +: dpath_width_p];
      if (i == 2 && imm_v_r)
        read_rs[i] = imm_r;
      else if (!src_fp_r[i] && (src_addr_r[i*reg_addr_width_p +: reg_addr_width_p] == '0))
        read_rs[i] = '0;
      else if (wb_match(wb_v_i, wb_fp_i, wb_addr_i, src_fp_r[i],
                        src_addr_r[i*reg_addr_width_p +: reg_addr_width_p], src_used_r[i]))
        read_rs[i] = wb_data_i;
      else if (wb_match(wb_v_r, wb_fp_r, wb_addr_r, src_fp_r[i],
                        src_addr_r[i*reg_addr_width_p +: reg_addr_width_p], src_used_r[i]))
        read_rs[i] = wb_data_r;

      hold_upd[i] = wb_match(wb_v_i, wb_fp_i, wb_addr_i, src_fp_r[i],
                             src_addr_r[i*reg_addr_width_p +: reg_addr_width_p], src_used_r[i])
                    ? wb_data_i : hold_rs_r[i];

      dispatch_rs_o[i*dpath_width_p +: dpath_width_p] =
        (state_r == HOLD) ? hold_rs_r[i] : read_rs[i];
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:       if (accept) state_n = READ;
      READ, HOLD: begin
        if (dispatch_ready_i) state_n = accept ? READ : IDLE;
        else                  state_n = HOLD;
      end
      default:    state_n = IDLE;
    endcase
    if (flush_i) state_n = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r    <= IDLE;
      pc_r       <= '0;
      instr_r    <= '0;
      imm_r      <= '0;
      imm_v_r    <= 1'b0;
      src_addr_r <= '0;
      src_fp_r   <= '0;
      wb_v_r     <= 1'b0;
      wb_fp_r    <= 1'b0;
      wb_addr_r  <= '0;
      wb_data_r  <= '0;
      for (int i = 0; i < 3; i++) hold_rs_r[i] <= '0;
    end else begin
      state_r   <= state_n;
      wb_v_r    <= wb_v_i;
      wb_fp_r   <= wb_fp_i;
      wb_addr_r <= wb_addr_i;
      wb_data_r <= wb_data_i;

      if (accept) begin
        pc_r       <= issue_pc_i;
        instr_r    <= issue_instr_i;
        imm_r      <= issue_imm_i;
        imm_v_r    <= issue_imm_v_i;
        src_addr_r <= issue_src_addr_i;
        src_fp_r   <= issue_src_fp_i;
      end

      // READ always snapshots resolved operands; HOLD keeps snooping writebacks.
      if (state_r == READ) begin
        for (int i = 0; i < 3; i++) hold_rs_r[i] <= read_rs[i];
      end else if (state_r == HOLD) begin
        for (int i = 0; i < 3; i++) hold_rs_r[i] <= hold_upd[i];
      end
    end
  end

endmodule

// File: tb/tb_bp_be_operand_fetch.sv
// Directed, table-driven bench for bp_be_operand_fetch with a small
// synchronous-read int/fp register file model behind the read ports.
module tb_bp_be_operand_fetch;

  logic         clk;
  logic         reset_n;
  logic         flush;
  logic         issue_v;
  logic         issue_ready;
  logic [38:0]  issue_pc;
  logic [31:0]  issue_instr;
  logic [14:0]  issue_src_addr;
  logic [2:0]   issue_src_fp;
  logic         issue_imm_v;
  logic [65:0]  issue_imm;
  logic [2:0]   rf_r_v;
  logic [2:0]   rf_r_fp;
  logic [14:0]  rf_r_addr;
  logic [197:0] rf_r_data;
  logic         wb_v;
  logic         wb_fp;
  logic [4:0]   wb_addr;
  logic [65:0]  wb_data;
  logic         dispatch_v;
  logic         dispatch_ready;
  logic [38:0]  dispatch_pc;
  logic [31:0]  dispatch_instr;
  logic [197:0] dispatch_rs;

  int n_cmp = 0;
  int n_err = 0;

  bp_be_operand_fetch dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .flush_i          (flush),
    .issue_v_i        (issue_v),
    .issue_ready_o    (issue_ready),
    .issue_pc_i       (issue_pc),
    .issue_instr_i    (issue_instr),
    .issue_src_addr_i (issue_src_addr),
    .issue_src_fp_i   (issue_src_fp),
    .issue_imm_v_i    (issue_imm_v),
    .issue_imm_i      (issue_imm),
    .rf_r_v_o         (rf_r_v),
    .rf_r_fp_o        (rf_r_fp),
    .rf_r_addr_o      (rf_r_addr),
    .rf_r_data_i      (rf_r_data),
    .wb_v_i           (wb_v),
    .wb_fp_i          (wb_fp),
    .wb_addr_i        (wb_addr),
    .wb_data_i        (wb_data),
    .dispatch_v_o     (dispatch_v),
    .dispatch_ready_i (dispatch_ready),
    .dispatch_pc_o    (dispatch_pc),
    .dispatch_instr_o (dispatch_instr),
    .dispatch_rs_o    (dispatch_rs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: reads sample the pre-edge contents, so a write in
  // the read cycle is not visible and must come from the bypass path.
  logic [65:0] int_rf [32];
  logic [65:0] fp_rf  [32];
  logic [65:0] rd     [3];

  assign rf_r_data = {rd[2], rd[1], rd[0]};

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 32; k++) begin
        int_rf[k] <= 66'h100 + 66'(k);
        fp_rf[k]  <= 66'h200 + 66'(k);
      end
      int_rf[0] <= '0;
      int_rf[1] <= 66'h10;
      int_rf[2] <= 66'h20;
      int_rf[3] <= 66'h30;
      int_rf[4] <= 66'h40;
      int_rf[5] <= 66'h1;
      for (int k = 0; k < 3; k++) rd[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++)
        if (rf_r_v[k])
          rd[k] <= rf_r_fp[k] ? fp_rf[rf_r_addr[k*5 +: 5]] : int_rf[rf_r_addr[k*5 +: 5]];
      if (wb_v && !(!wb_fp && wb_addr == 5'd0)) begin
        if (wb_fp) fp_rf[wb_addr]  <= wb_data;
        else       int_rf[wb_addr] <= wb_data;
      end
    end
  end

  typedef struct {
    logic        iv;
    logic [38:0] pc;
    logic [4:0]  a0, a1, a2;
    logic [2:0]  fp;
    logic        imm_v;
    logic [65:0] imm;
    logic        wbv, wbfp;
    logic [4:0]  wba;
    logic [65:0] wbd;
    logic        rdy, fl;
    logic        e_dv, e_ir;
    logic [2:0]  e_rfv;
    logic [38:0] e_pc;
    logic [65:0] e0, e1, e2;
  } vec_t;

  function automatic vec_t row(
    input logic iv, input logic [38:0] pc,
    input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
    input logic [2:0] fp, input logic imm_v, input logic [65:0] imm,
    input logic wbv, input logic wbfp, input logic [4:0] wba, input logic [65:0] wbd,
    input logic rdy, input logic fl,
    input logic e_dv, input logic e_ir, input logic [2:0] e_rfv, input logic [38:0] e_pc,
    input logic [65:0] e0, input logic [65:0] e1, input logic [65:0] e2
  );
    vec_t v;
    v.iv = iv; v.pc = pc; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.fp = fp;
    v.imm_v = imm_v; v.imm = imm; v.wbv = wbv; v.wbfp = wbfp; v.wba = wba; v.wbd = wbd;
    v.rdy = rdy; v.fl = fl; v.e_dv = e_dv; v.e_ir = e_ir; v.e_rfv = e_rfv; v.e_pc = e_pc;
    v.e0 = e0; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  function automatic logic [31:0] instr_of(input logic [38:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_v        = v.iv;
    issue_pc       = v.pc;
    issue_instr    = instr_of(v.pc);
    issue_src_addr = {v.a2, v.a1, v.a0};
    issue_src_fp   = v.fp;
    issue_imm_v    = v.imm_v;
    issue_imm      = v.imm;
    wb_v           = v.wbv;
    wb_fp          = v.wbfp;
    wb_addr        = v.wba;
    wb_data        = v.wbd;
    dispatch_ready = v.rdy;
    flush          = v.fl;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    check($sformatf("r%0d dispatch_v", idx), 66'(dispatch_v), 66'(v.e_dv));
    check($sformatf("r%0d issue_ready", idx), 66'(issue_ready), 66'(v.e_ir));
    check($sformatf("r%0d rf_r_v", idx), 66'(rf_r_v), 66'(v.e_rfv));
    if (v.e_dv) begin
      check($sformatf("r%0d pc", idx), 66'(dispatch_pc), 66'(v.e_pc));
      check($sformatf("r%0d instr", idx), 66'(dispatch_instr), 66'(instr_of(v.e_pc)));
      check($sformatf("r%0d rs1", idx), dispatch_rs[65:0], v.e0);
      check($sformatf("r%0d rs2", idx), dispatch_rs[131:66], v.e1);
      check($sformatf("r%0d rs3", idx), dispatch_rs[197:132], v.e2);
    end
  endtask

  vec_t vecs [27];
  vec_t idle_v;

  initial begin
    // back-to-back x1..x4
    vecs[0]  = row(1,'h1000, 1,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 0,1,3'b111,0,      0,0,0);
    vecs[1]  = row(1,'h1004, 2,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 1,1,3'b111,'h1000, 'h10,0,0);
    vecs[2]  = row(1,'h1008, 3,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 1,1,3'b111,'h1004, 'h20,0,0);
    vecs[3]  = row(1,'h100C, 4,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 1,1,3'b111,'h1008, 'h30,0,0);
    vecs[4]  = row(0,0,      0,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 1,1,3'b000,'h100C, 'h40,0,0);
    vecs[5]  = row(0,0,      0,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 0,1,3'b000,0,      0,0,0);
    // forwarding: youngest write wins, then registered write
    vecs[6]  = row(1,'h1100, 5,0,0, 3'b000,0,0,     1,0,5,'hAA,  1,0, 0,1,3'b111,0,      0,0,0);
    vecs[7]  = row(0,0,      0,0,0, 3'b000,0,0,     1,0,5,'hBB,  1,0, 1,1,3'b000,'h1100, 'hBB,0,0);
    vecs[8]  = row(1,'h1104, 6,0,0, 3'b000,0,0,     1,0,6,'hAA,  1,0, 0,1,3'b111,0,      0,0,0);
    vecs[9]  = row(0,0,      0,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 1,1,3'b000,'h1104, 'hAA,0,0);
    // stall: three cycles not ready, fp f3 written while holding
    vecs[10] = row(1,'h2000, 1,3,3, 3'b010,0,0,     0,0,0,0,     1,0, 0,1,3'b111,0,      0,0,0);
    vecs[11] = row(0,0,      0,0,0, 3'b000,0,0,     0,0,0,0,     0,0, 1,0,3'b000,'h2000, 'h10,'h203,'h30);
    vecs[12] = row(0,0,      0,0,0, 3'b000,0,0,     1,1,3,'h77,  0,0, 1,0,3'b000,'h2000, 'h10,'h203,'h30);
    vecs[13] = row(0,0,      0,0,0, 3'b000,0,0,     0,0,0,0,     0,0, 1,0,3'b000,'h2000, 'h10,'h77,'h30);
    vecs[14] = row(1,'h2004, 2,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 1,1,3'b111,'h2000, 'h10,'h77,'h30);
    vecs[15] = row(0,0,      0,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 1,1,3'b000,'h2004, 'h20,0,0);
    // x0 never bypassed, fp write does not hit int source, immediate slot
    vecs[16] = row(1,'h2100, 0,2,0, 3'b000,1,'h123, 1,0,0,'h5,   1,0, 0,1,3'b011,0,      0,0,0);
    vecs[17] = row(0,0,      0,0,0, 3'b000,0,0,     1,1,2,'h99,  1,0, 1,1,3'b000,'h2100, 0,'h20,'h123);
    // flush in HOLD, flush in accept cycle, then a clean issue
    vecs[18] = row(1,'h3000, 1,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 0,1,3'b111,0,      0,0,0);
    vecs[19] = row(0,0,      0,0,0, 3'b000,0,0,     0,0,0,0,     0,0, 1,0,3'b000,'h3000, 'h10,0,0);
    vecs[20] = row(1,'h3004, 2,0,0, 3'b000,0,0,     0,0,0,0,     0,1, 0,0,3'b000,0,      0,0,0);
    vecs[21] = row(0,0,      0,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 0,1,3'b000,0,      0,0,0);
    vecs[22] = row(1,'h3008, 3,0,0, 3'b000,0,0,     0,0,0,0,     1,1, 0,0,3'b000,0,      0,0,0);
    vecs[23] = row(0,0,      0,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 0,1,3'b000,0,      0,0,0);
    vecs[24] = row(1,'h300C, 2,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 0,1,3'b111,0,      0,0,0);
    vecs[25] = row(0,0,      0,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 1,1,3'b000,'h300C, 'h20,0,0);
    vecs[26] = row(0,0,      0,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 0,1,3'b000,0,      0,0,0);
    idle_v   = row(0,0,      0,0,0, 3'b000,0,0,     0,0,0,0,     1,0, 0,0,3'b000,0,      0,0,0);

    reset_n = 1'b0;
    drive(idle_v);

    // Reset state: both handshakes low while reset is held.
    @(negedge clk);
    #1;
    check("reset dispatch_v", 66'(dispatch_v), 66'(0));
    check("reset issue_ready", 66'(issue_ready), 66'(0));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("release issue_ready", 66'(issue_ready), 66'(1));
    check("release dispatch_v", 66'(dispatch_v), 66'(0));

    for (int i = 0; i < 27; i++) apply(vecs[i], i);

    // Reset asserted mid-READ drops the instruction.
    apply(vecs[0], 100);
    @(negedge clk);
    drive(idle_v);
    reset_n = 1'b0;
    #1;
    check("rst-in-read dispatch_v", 66'(dispatch_v), 66'(0));
    check("rst-in-read issue_ready", 66'(issue_ready), 66'(0));
    @(negedge clk);
    #1;
    check("rst-held dispatch_v", 66'(dispatch_v), 66'(0));
    check("rst-held issue_ready", 66'(issue_ready), 66'(0));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post-rst issue_ready", 66'(issue_ready), 66'(1));
    check("post-rst dispatch_v", 66'(dispatch_v), 66'(0));
    @(negedge clk);
    #1;
    check("post-rst no stale beat", 66'(dispatch_v), 66'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bp_be_operand_fetch.md
Name: bp_be_operand_fetch

Overview:
Producer side of the dispatch-packet/bypass-operand interface. It accepts decoded issue packets, drives a 3-port synchronous-read register file (int and fp), and forwards in-flight writebacks. It presents one dispatch beat per instruction (packet fields plus rs1/rs2/rs3 operands) to the reservation register. It absorbs downstream stalls by holding operands, while continuing to snoop writebacks.

Parameters:
vaddr_width_p, 39, PC width
instr_width_p, 32, instruction width
dpath_width_p, 66, operand width (recoded datapath width)
reg_addr_width_p, 5, architectural register index width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, synchronous, active-low
flush_i  in  1  kill any in-flight instruction
issue_v_i  in  1  issue packet valid
issue_ready_o  out  1  block can accept issue packet
issue_pc_i  in  vaddr_width_p  instruction PC
issue_instr_i  in  instr_width_p  instruction bits
issue_src_addr_i  in  3*reg_addr_width_p  rs1/rs2/rs3 indices, [0]=rs1
issue_src_fp_i  in  3  per source: 1=fp file, 0=int file
issue_imm_v_i  in  1  slot 2 carries the immediate, not rs3
issue_imm_i  in  dpath_width_p  immediate value
rf_r_v_o  out  3  register file read enables
rf_r_fp_o  out  3  file select per read port
rf_r_addr_o  out  3*reg_addr_width_p  read indices
rf_r_data_i  in  3*dpath_width_p  read data, valid the cycle after rf_r_v_o
wb_v_i  in  1  writeback valid
wb_fp_i  in  1  writeback targets fp file
wb_addr_i  in  reg_addr_width_p  writeback index
wb_data_i  in  dpath_width_p  writeback data
dispatch_v_o  out  1  dispatch beat valid
dispatch_ready_i  in  1  downstream accepts beat
dispatch_pc_o  out  vaddr_width_p  PC of beat
dispatch_instr_o  out  instr_width_p  instruction of beat
dispatch_rs_o  out  3*dpath_width_p  operands [0]=rs1,[1]=rs2,[2]=rs3/imm

Behaviour:
- Reset (reset_n_i=0 at a clock edge):
  - state=IDLE.
  - dispatch_v_o=0, issue_ready_o=0 while reset_n_i is low; 1 in IDLE thereafter.
  - rf_r_v_o=0; all held registers cleared to 0.
- States:
  - IDLE: no instruction held.
  - READ: RF data arriving this cycle.
  - HOLD: operands registered, waiting for dispatch_ready_i.
- Accept: handshake issue_v_i & issue_ready_o in cycle N.
  - rf_r_v_o[i] = handshake & source used. Slot 2 is unused when issue_imm_v_i=1.
  - RF addr/fp driven combinationally from the issue inputs.
  - pc, instr, imm, src addr/fp and imm_v registered; state->READ.
- issue_ready_o = (state==IDLE) | (dispatch_v_o & dispatch_ready_i), gated by !flush_i.
- Latency and throughput:
  - dispatch_v_o=1 in cycle N+1 (READ), operands muxed combinationally.
  - Sustained throughput 1 instr/cycle when dispatch_ready_i stays high.
- READ transitions:
  - ready & new accept -> READ.
  - ready & no accept -> IDLE.
  - !ready -> HOLD, capturing the resolved operands into hold registers.
- HOLD transitions:
  - Outputs driven from hold registers.
  - ready & accept -> READ; ready & no accept -> IDLE; else stay.
- RF contract: data at N+1 reflects writes up to N-1. Writes in cycle N and later are forwarded.
  - wb at N is registered (wb_r).
  - READ operand = wb_i if it matches, else wb_r if it matches, else rf_r_data_i. The youngest write wins.
  - In HOLD, a matching wb_i updates the hold register at the clock edge.
- Match rule:
  - wb_v & fp equal & addr equal & source used & !(int & addr==0).
  - Int x0 always reads 0 and is never bypassed.
- Slot 2 with imm_v: output = registered imm, never bypassed.
- Unused source slots output 0.
- flush_i in any cycle:
  - dispatch_v_o=0 and issue_ready_o=0 that cycle; rf_r_v_o=0.
  - state->IDLE next cycle; any issue_v_i that cycle is ignored.
  - flush_i dominates dispatch_ready_i and reset-free transitions.
- Reset asserted mid-READ or mid-HOLD: the instruction is dropped; no dispatch beat after reset release until a new accept.
- dispatch_pc/instr/rs_o hold stable while dispatch_v_o & !dispatch_ready_i.

Test Plan:
- Back-to-back: 4 issues, rs1=x1..x4 preloaded 0x10..0x40, ready=1 -> dispatch_v_o high cycles N+1..N+4 with rs1 0x10..0x40; issue_ready_o never drops.
- Forwarding: issue rs1=int x5 (RF=0x1) with wb x5=0xAA at cycle N and wb x5=0xBB at N+1 -> dispatch rs1=0xBB; wb at N only -> 0xAA.
- Stall: ready=0 for 3 cycles, fp f3 written 0x77 during HOLD -> operands stable except rs2(f3) becomes 0x77; beat accepted on the cycle ready rises; issue_ready_o=1 that cycle.
- x0/fp separation and imm: rs1=int x0 with wb int x0=0x5 -> 0. wb fp x2 while source is int x2 -> no bypass. imm_v=1, imm=0x123 -> rs_o[2]=0x123 and rf_r_v_o[2]=0.
- Flush in HOLD and in accept cycle -> dispatch_v_o=0 that cycle, IDLE next, the issued packet is never dispatched.
- Reset (reset_n_i=0) during READ -> dispatch_v_o=0 and issue_ready_o=0 while low; after release issue_ready_o=1 and no stale beat.
